// File: rtl/lsu_bus_adapter_pkg.sv
// lsu_pkg: shared encodings, FSM states and byte-enable patterns for the LSU bus adapter
package lsu_pkg;

    typedef enum logic [2:0] {
        RC_NONE = 3'd0,
        RC_LB   = 3'd1,
        RC_LH   = 3'd2,
        RC_LW   = 3'd3,
        RC_LBU  = 3'd4,
        RC_LHU  = 3'd5
    } rc_e;

    typedef enum logic [2:0] {
        WC_NONE = 3'd0,
        WC_SB   = 3'd1,
        WC_SH   = 3'd2,
        WC_SW   = 3'd3
    } wc_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_e;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

endpackage

// File: rtl/lsu_bus_adapter_load_extend.sv
// load_extend: selects the addressed lane of a loaded word and sign/zero-extends it
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  op,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        b      = 8'(word >> {offset, 3'b000});
        h      = offset[1] ? word[31:16] : word[15:0];
        result = op == RC_LB  ? {{24{b[7]}}, b} :
                 op == RC_LBU ? {24'b0, b} :
                 op == RC_LH  ? {{16{h[15]}}, h} :
                 op == RC_LHU ? {16'b0, h} : word;
    end

endmodule

// File: rtl/lsu_bus_adapter.sv
// lsu_bus_adapter: turns core load/store controls into handshaked word-aligned bus transactions
module lsu_bus_adapter
    import lsu_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        ReadControl,
    input  logic [2:0]        WriteControl,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              stall,
    output logic              done,
    output logic              misaligned,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;

    state_e        state;
    logic [CW-1:0] cnt;
    logic [2:0]    op_q;
    logic [1:0]    off_q;
    logic [31:0]   rdata_q;
    logic [31:0]   ext;
    logic          st_v;
    logic          ld_v;
    logic          active;
    logic          is_b;
    logic          is_h;
    logic          mis;
    logic          tmo;
    logic [3:0]    be;
    logic [31:0]   wdata;

    load_extend u_ext (
        .word  (rdata_q),
        .offset(off_q),
        .op    (op_q),
        .result(ext)
    );

    // a valid store code overrides any simultaneous load code
    always_comb begin
        st_v       = WriteControl inside {WC_SB, WC_SH, WC_SW};
        ld_v       = ReadControl inside {RC_LB, RC_LH, RC_LW, RC_LBU, RC_LHU};
        active     = st_v || ld_v;
        is_b       = st_v ? WriteControl == WC_SB : ReadControl inside {RC_LB, RC_LBU};
        is_h       = st_v ? WriteControl == WC_SH : ReadControl inside {RC_LH, RC_LHU};
        mis        = active && (is_h ? Address[0] : !is_b && Address[1:0] != 2'b00);
        be         = is_b ? BE_B << Address[1:0] : is_h ? BE_H << Address[1:0] : BE_W;
        wdata      = !st_v ? '0 : is_b ? {4{WriteData[7:0]}} : is_h ? {2{WriteData[15:0]}} : WriteData;
        tmo        = TIMEOUT > 0 && state == S_WAIT && !mem_rvalid && cnt == CW'(TIMEOUT - 1);
        stall      = (state == S_IDLE && active && !mis) || state == S_REQ || (state == S_WAIT && !tmo);
        done       = state == S_DONE;
        misaligned = state == S_IDLE && mis;
        bus_err    = tmo;
        mem_req    = state == S_REQ;
        ReadData   = done && !mem_we ? ext : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cnt     <= '0;
            rdata_q <= '0;
            op_q    <= '0;
            off_q   <= '0;
            {mem_we, mem_be, mem_addr, mem_wdata} <= '0;
        end else begin
            case (state)
                S_IDLE: if (active && !mis) begin
                    state     <= S_REQ;
                    op_q      <= st_v ? '0 : ReadControl;
                    off_q     <= Address[1:0];
                    mem_we    <= st_v;
                    mem_be    <= be;
                    mem_addr  <= {Address[ADDR_W-1:2], 2'b00};
                    mem_wdata <= wdata;
                end
                S_REQ: if (mem_gnt) begin
                    cnt   <= '0;
                    state <= mem_rvalid ? S_DONE : S_WAIT;
                    if (mem_rvalid) rdata_q <= mem_rdata;
                end
                S_WAIT: if (mem_rvalid) begin
                    rdata_q <= mem_rdata;
                    state   <= S_DONE;
                end else if (tmo) begin
                    state <= S_IDLE;
                    {mem_we, mem_be, mem_addr, mem_wdata} <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    {mem_we, mem_be, mem_addr, mem_wdata} <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bus_adapter.sv
// tb_lsu_bus_adapter: scoreboard bench with a spec-level model of the load/store bus adapter
module tb_lsu_bus_adapter;
    localparam int TMO = 16;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } req_t;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  ReadControl;
    logic [2:0]  WriteControl;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        stall;
    logic        done;
    logic        misaligned;
    logic        bus_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    req_t req_q[$];
    exp_t me;

    lsu_bus_adapter #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .ReadControl (ReadControl),
        .WriteControl(WriteControl),
        .Address     (Address),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .stall       (stall),
        .done        (done),
        .misaligned  (misaligned),
        .bus_err     (bus_err),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_be      (mem_be),
        .mem_wdata   (mem_wdata),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: completions and bus requests are checked against the queued expectations
    always @(negedge clk) begin
        if (!rst) begin
            if (done || misaligned || bus_err) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_completion: got %b expected none", {done, misaligned, bus_err});
                end else begin
                    me = exp_q.pop_front();
                    chk("completion_kind", {done, misaligned, bus_err}, me.kind);
                    chk("read_data", ReadData, me.data);
                end
            end
            if (mem_req) begin
                if (req_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_request: got addr %0h expected none", mem_addr);
                end else begin
                    chk("bus_request", {mem_addr, mem_be, mem_wdata, mem_we}, req_q[0]);
                    if (mem_gnt) void'(req_q.pop_front());
                end
            end
            if (!stall && !done && !bus_err && !mem_req)
                chk("idle_bus_zero", {mem_addr, mem_be, mem_wdata, mem_we, ReadData}, '0);
        end
    end

    task automatic clear_inputs();
        ReadControl  = '0;
        WriteControl = '0;
        Address      = '0;
        WriteData    = '0;
        mem_gnt      = 1'b0;
        mem_rvalid   = 1'b0;
    endtask

    // issues one op, models the expected outcome, and plays the memory side with given delays
    task automatic run_op(input logic [2:0] rc, input logic [2:0] wc, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rdv, input int gd, input int rdl,
                          input bit hang);
        bit     st, sgn, act, mis, granted, fin;
        int     sz, o, cyc, reqc, stallc, wt, ecyc;
        longint v;
        req_t   r;
        exp_t   e;
        st  = wc inside {[3'd1:3'd3]};
        act = st || (rc inside {[3'd1:3'd5]});
        sz  = st ? (1 << (int'(wc) - 1)) : rc == 3'd3 ? 4 : (rc == 3'd2 || rc == 3'd5) ? 2 : 1;
        sgn = !st && (rc == 3'd1 || rc == 3'd2);
        o   = int'(a[1:0]);
        mis = (o % sz) != 0;
        r.addr  = {a[31:2], 2'b00};
        r.we    = st;
        r.be    = '0;
        r.wdata = '0;
        for (int i = 0; i < 4; i++) begin
            r.be[i] = i >= o && i < o + sz;
            if (st) r.wdata[8*i +: 8] = wd[8*(i % sz) +: 8];
        end
        v = (longint'(rdv) >> (8 * o)) & ((longint'(1) << (8 * sz)) - 1);
        if (sgn && v[8*sz-1]) v -= longint'(1) << (8 * sz);
        ReadControl  = rc;
        WriteControl = wc;
        Address      = a;
        WriteData    = wd;
        if (!act) begin
            @(negedge clk);
            chk("noop_quiet", {stall, mem_req, done, misaligned}, 0);
            @(posedge clk);
            #1;
            clear_inputs();
            return;
        end
        e.kind = mis ? 3'b010 : hang ? 3'b001 : 3'b100;
        e.data = (mis || hang || st) ? 32'h0 : v[31:0];
        exp_q.push_back(e);
        if (!mis) req_q.push_back(r);
        ecyc = mis ? 0 : hang ? gd + 1 + TMO : gd + 2 + rdl;
        cyc = 0; reqc = 0; stallc = 0; wt = 0; granted = 0; fin = 0;
        while (!fin && cyc < 100) begin
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            if (mem_req) begin
                mem_gnt = reqc == gd;
                if (mem_gnt) begin
                    granted    = 1;
                    mem_rvalid = !hang && rdl == 0;
                end else begin
                    mem_rvalid = 1'($urandom_range(0, 1));
                end
            end else if (granted) begin
                wt++;
                mem_rvalid = !hang && wt == rdl;
            end
            if (mem_rvalid && (mem_gnt || !mem_req)) mem_rdata = rdv;
            @(negedge clk);
            reqc   += int'(mem_req);
            stallc += int'(stall);
            fin     = done || misaligned || bus_err;
            if (!fin) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        chk("latency", cyc, ecyc);
        chk("stall_cycles", stallc, ecyc);
        chk("req_cycles", reqc, mis ? 0 : gd + 1);
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        mem_rdata = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {ReadData, stall, done, misaligned, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata}, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        run_op(3'd3, 3'd0, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0, 0);
        run_op(3'd1, 3'd0, 32'h13, 32'h0, 32'h80112233, 0, 0, 0);
        run_op(3'd4, 3'd0, 32'h13, 32'h0, 32'h80112233, 1, 1, 0);
        run_op(3'd0, 3'd2, 32'h22, 32'h1234ABCD, 32'h0, 3, 2, 0);
        run_op(3'd3, 3'd0, 32'h15, 32'h0, 32'h0, 0, 0, 0);
        run_op(3'd0, 3'd2, 32'h21, 32'h1, 32'h0, 0, 0, 0);
        run_op(3'd5, 3'd1, 32'h7, 32'hA5, 32'hFFFF0000, 0, 1, 0);
        run_op(3'd2, 3'd0, 32'h102, 32'h0, 32'h8001_7FFF, 2, 3, 0);
        run_op(3'd3, 3'd0, 32'h40, 32'h0, 32'h0, 1, 0, 1);

        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        chk("late_rvalid_ignored", {done, stall, bus_err, mem_req}, 0);
        @(posedge clk);
        #1;
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rvalid_no_done", {done, ReadData}, 0);

        @(posedge clk);
        #1;
        ReadControl = 3'd3;
        Address     = 32'h80;
        req_q.push_back('{addr: 32'h80, be: 4'hF, wdata: 32'h0, we: 1'b0});
        @(posedge clk);
        #1;
        mem_gnt = 1'b1;
        @(posedge clk);
        #1;
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("wait_stall", {stall, mem_req}, 2'b10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_wait_outputs", {ReadData, stall, done, misaligned, bus_err, mem_req, mem_we, mem_addr, mem_be, mem_wdata}, '0);
        @(posedge clk);
        #1;
        run_op(3'd0, 3'd3, 32'h0, 32'h55, 32'h0, 0, 1, 0);

        for (int n = 0; n < 150; n++) begin
            run_op(3'($urandom_range(0, 7)),
                   ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0,
                   $urandom, $urandom, $urandom,
                   int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                   $urandom_range(0, 19) == 0);
        end

        repeat (3) @(negedge clk);
        chk("exp_queue_drained", exp_q.size(), 0);
        chk("req_queue_drained", req_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsu_bus_adapter.md
Name: lsu_bus_adapter

Overview:
- Multi-cycle load/store unit directly downstream of the core datapath's ALU/RD2 outputs. It replaces the single-cycle data memory port with a handshaked memory bus.
- Converts ReadControl/WriteControl plus address and store data into word-aligned bus requests with byte enables. Sign- or zero-extends load data.
- Stalls the core until each transaction completes. Flags misaligned accesses and bus timeouts.

Parameters:
- ADDR_W, 32, width of byte address on core and bus side
- TIMEOUT, 16, max cycles waiting for mem_rvalid after grant before bus_err; 0 disables timeout

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- ReadControl  input  3  000 none, 001 LB, 010 LH, 011 LW, 100 LBU, 101 LHU; 110/111 treated as none
- WriteControl  input  3  000 none, 001 SB, 010 SH, 011 SW; 100-111 treated as none
- Address  input  ADDR_W  byte address (ALU result)
- WriteData  input  32  store data (RD2), LSB-aligned
- ReadData  output  32  extended load result, valid while done=1
- stall  output  1  core must hold PC/regfile write and keep inputs stable while high
- done  output  1  one-cycle pulse, transaction complete
- misaligned  output  1  one-cycle pulse, access rejected
- bus_err  output  1  one-cycle pulse, timeout
- mem_req  output  1  bus request, held until mem_gnt
- mem_we  output  1  1=store
- mem_addr  output  ADDR_W  word-aligned address (Address with [1:0]=00)
- mem_be  output  4  byte enables
- mem_wdata  output  32  lane-replicated store data
- mem_gnt  input  1  bus accepts request this cycle
- mem_rvalid  input  1  response (load data or store ack) valid
- mem_rdata  input  32  load word

Behaviour:
- States: IDLE, REQ, WAIT, DONE. Reset: state IDLE, all outputs 0, timeout counter 0.
- Op active = decoded ReadControl valid OR WriteControl valid. If both are set, the store wins.
- IDLE, op active:
  - Misaligned (LH/LHU/SH with Address[0]=1; LW/SW with Address[1:0]!=00): misaligned=1 that cycle, stall=0, no bus activity, stay IDLE.
  - Aligned: stall=1 combinationally. Latch op, offset, mem_addr, mem_be, mem_wdata, mem_we. Go to REQ.
- IDLE, no op: stall=0.
- REQ: mem_req=1, stall=1.
  - mem_gnt=0: stay in REQ.
  - mem_gnt=1 and mem_rvalid=1: capture data and go to DONE.
  - mem_gnt=1 only: go to WAIT. Clear the counter.
- WAIT: stall=1, mem_req=0.
  - mem_rvalid=1: capture mem_rdata and go to DONE.
  - TIMEOUT>0 and counter reaches TIMEOUT-1 without rvalid: bus_err=1 for that cycle. ReadData=0, stall=0 that cycle, go to IDLE. The core treats the op as retired.
- DONE: done=1, stall=0, ReadData valid. Always go to IDLE next cycle. The held op is not re-issued because the core advances on this edge.
- Minimum latency, gnt and rvalid both high in REQ: op seen cycle 0, DONE cycle 2.
- Byte enables by offset o=Address[1:0]:
  - byte: 0001<<o
  - half: 0011<<o
  - word: 1111
- Loads drive mem_be too.
- Store data:
  - SB: {4{WriteData[7:0]}}
  - SH: {2{WriteData[15:0]}}
  - SW: WriteData
- Load extract: select lane by latched offset.
  - LB/LH sign-extend bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
  - Store completion: ReadData=0.
- mem_addr/mem_be/mem_wdata/mem_we are held constant from REQ until completion. They are 0 in IDLE.
- rst asserted in any state: next edge → IDLE, mem_req=0, all outputs 0. A late mem_rvalid arriving in IDLE is ignored.
- mem_rvalid while in REQ without mem_gnt is ignored.

Decomposition:
- Shared package lsu_pkg:
  - ReadControl/WriteControl encodings (LB..LHU, SB..SW, NONE)
  - state enum
  - byte-enable constants
- One sub-module, load_extend: combinational lane select plus sign/zero extension. Inputs: word, offset, op. Output: 32-bit result.
- FSM, latching, and store replication stay in the top module.

Test Plan:
- LW Address=0x0000_0010, memory returns 0xDEADBEEF with gnt and rvalid together → mem_addr=0x10, be=1111, stall high 2 cycles, done in cycle 2, ReadData=0xDEADBEEF.
- LB Address=0x13, rdata=0x80AA_BB CC-lane pattern 0x80112233 → be=1000, ReadData=0xFFFFFF80. LBU with the same data → ReadData=0x00000080.
- SH Address=0x22, WriteData=0x1234ABCD, gnt delayed 3 cycles, rvalid 2 cycles later → mem_wdata=0xABCDABCD, be=1100, mem_we=1, mem_req held 4 cycles, done once.
- LW Address=0x15 → misaligned pulse, mem_req never asserts, stall=0. SH at 0x21 also faults.
- TIMEOUT=16, LW granted, no rvalid → bus_err exactly 16 cycles after grant, ReadData=0, return to IDLE. A late rvalid is ignored.
- rst asserted in WAIT → next cycle IDLE, all outputs 0. A following SW Address=0x0, WriteData=0x55 completes normally.
